// File: rtl/crc32_stream_engine.sv
// Streaming CRC-32 (reflected, poly 0x04C11DB7) over DATA_BYTES bytes per beat.
// Generates the FCS or checks a frame with its FCS appended, using the residue.
module crc32_stream_engine #(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] INIT_VAL   = 32'hFFFF_FFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFF_FFFF,
    parameter logic [31:0] RESIDUE    = 32'hDEBB_20E3,
    parameter bit          OUT_REG    = 1'b0
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic [8*DATA_BYTES-1:0] crc_din,
    input  logic [DATA_BYTES-1:0]   crc_keep,
    input  logic                    crc_din_vld,
    input  logic                    crc_sop,
    input  logic                    crc_eop,
    input  logic                    crc_mode,
    output logic [31:0]             crc_dout,
    output logic                    crc_dout_vld,
    output logic                    crc_ok,
    output logic [15:0]             crc_len,
    output logic                    crc_seq_err,
    output logic                    crc_state_dbg
);
    localparam logic [31:0] POLY = 32'hEDB8_8320;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] flen_q, flen_d;
    logic        mode_q, mode_d;
    logic        seq_err_q, seq_err_d;

    logic [31:0] beat_crc;
    logic [15:0] beat_len;
    logic [3:0]  nbytes;
    logic [16:0] len_sum;
    logic        accept;
    logic        res_vld_d;
    logic        res_mode;
    logic        res_ok_d;

    logic        r1_vld_q;
    logic [31:0] r1_dout_q;
    logic        r1_ok_q;
    logic [15:0] r1_len_q;

    // A sop beat always restarts from INIT_VAL, so the seed is chosen here
    // rather than by the FSM; non-eop beats use every byte regardless of keep.
    always_comb begin
        beat_crc = crc_sop ? INIT_VAL : crc_q;
        nbytes   = 4'd0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (!crc_eop || crc_keep[b]) begin
                beat_crc = beat_crc ^ {24'h0, crc_din[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    beat_crc = beat_crc[0] ? ((beat_crc >> 1) ^ POLY) : (beat_crc >> 1);
                end
                nbytes = nbytes + 4'd1;
            end
        end
        len_sum  = {1'b0, (crc_sop ? 16'h0 : flen_q)} + {13'h0, nbytes};
        beat_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        res_mode = crc_sop ? crc_mode : mode_q;
        res_ok_d = res_mode && (beat_crc == RESIDUE) && (beat_len >= 16'd4);
    end

    // Handshake: a beat is taken on every cycle crc_din_vld is high; there is
    // no ready signal and the engine never stalls.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        flen_d    = flen_q;
        mode_d    = mode_q;
        seq_err_d = 1'b0;
        res_vld_d = 1'b0;
        accept    = 1'b0;
        if (crc_din_vld) begin
            if (crc_sop) begin
                seq_err_d = (state_q == ACTIVE);
                mode_d    = crc_mode;
                accept    = 1'b1;
            end else if (state_q == ACTIVE) begin
                accept = 1'b1;
            end else begin
                seq_err_d = 1'b1;
            end
            if (accept) begin
                if (crc_eop) begin
                    state_d   = IDLE;
                    crc_d     = INIT_VAL;
                    flen_d    = 16'h0;
                    res_vld_d = 1'b1;
                end else begin
                    state_d = ACTIVE;
                    crc_d   = beat_crc;
                    flen_d  = beat_len;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q   <= IDLE;
            crc_q     <= INIT_VAL;
            flen_q    <= 16'h0;
            mode_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            flen_q    <= flen_d;
            mode_q    <= mode_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r1_vld_q  <= 1'b0;
            r1_dout_q <= 32'h0;
            r1_ok_q   <= 1'b0;
            r1_len_q  <= 16'h0;
        end else begin
            r1_vld_q <= res_vld_d;
            if (res_vld_d) begin
                r1_dout_q <= beat_crc ^ XOR_OUT;
                r1_ok_q   <= res_ok_d;
                r1_len_q  <= beat_len;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic        r2_vld_q;
            logic [31:0] r2_dout_q;
            logic        r2_ok_q;
            logic [15:0] r2_len_q;

            always_ff @(posedge clk_sys or posedge rst_sys) begin
                if (rst_sys) begin
                    r2_vld_q  <= 1'b0;
                    r2_dout_q <= 32'h0;
                    r2_ok_q   <= 1'b0;
                    r2_len_q  <= 16'h0;
                end else begin
                    r2_vld_q <= r1_vld_q;
                    if (r1_vld_q) begin
                        r2_dout_q <= r1_dout_q;
                        r2_ok_q   <= r1_ok_q;
                        r2_len_q  <= r1_len_q;
                    end
                end
            end

            assign crc_dout     = r2_dout_q;
            assign crc_dout_vld = r2_vld_q;
            assign crc_ok       = r2_ok_q;
            assign crc_len      = r2_len_q;
        end else begin : g_no_out_reg
            assign crc_dout     = r1_dout_q;
            assign crc_dout_vld = r1_vld_q;
            assign crc_ok       = r1_ok_q;
            assign crc_len      = r1_len_q;
        end
    endgenerate

    assign crc_seq_err   = seq_err_q;
    assign crc_state_dbg = state_q;
endmodule

// File: tb/tb_crc32_stream_engine.sv
// Bench for crc32_stream_engine: 4-byte/OUT_REG=0, 1-byte/OUT_REG=0 and 4-byte/OUT_REG=1
// instances, checked against a bit-serial CRC-32 model and known vectors.
module tb_crc32_stream_engine;
    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic rst_sys;
    int   cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // shared inputs for the two 4-byte instances, separate ones for the 1-byte one
    logic [31:0] din;
    logic [3:0]  keep;
    logic        vld, sop, eop, mode;
    logic [7:0]  din1;
    logic [0:0]  keep1;
    logic        vld1, sop1, eop1, mode1;

    logic [31:0] o_dout[3];
    logic        o_vld[3], o_ok[3], o_seq[3], o_st[3];
    logic [15:0] o_len[3];

    crc32_stream_engine #(.DATA_BYTES(4), .OUT_REG(1'b0)) dut0 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(din), .crc_keep(keep),
        .crc_din_vld(vld), .crc_sop(sop), .crc_eop(eop), .crc_mode(mode),
        .crc_dout(o_dout[0]), .crc_dout_vld(o_vld[0]), .crc_ok(o_ok[0]),
        .crc_len(o_len[0]), .crc_seq_err(o_seq[0]), .crc_state_dbg(o_st[0]));

    crc32_stream_engine #(.DATA_BYTES(1), .OUT_REG(1'b0)) dut1 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(din1), .crc_keep(keep1),
        .crc_din_vld(vld1), .crc_sop(sop1), .crc_eop(eop1), .crc_mode(mode1),
        .crc_dout(o_dout[1]), .crc_dout_vld(o_vld[1]), .crc_ok(o_ok[1]),
        .crc_len(o_len[1]), .crc_seq_err(o_seq[1]), .crc_state_dbg(o_st[1]));

    crc32_stream_engine #(.DATA_BYTES(4), .OUT_REG(1'b1)) dut2 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .crc_din(din), .crc_keep(keep),
        .crc_din_vld(vld), .crc_sop(sop), .crc_eop(eop), .crc_mode(mode),
        .crc_dout(o_dout[2]), .crc_dout_vld(o_vld[2]), .crc_ok(o_ok[2]),
        .crc_len(o_len[2]), .crc_seq_err(o_seq[2]), .crc_state_dbg(o_st[2]));

    always @(posedge clk_sys)
        if (vld && eop) assert ((keep & (keep + 4'd1)) == 4'd0) else $error("non-contiguous keep driven");

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] dout;
        logic        ok;
        logic [15:0] len;
        int          cyc;
    } exp_t;

    exp_t       exp_q[3][$];
    exp_t       mon_e;
    logic [7:0] fbytes[$];
    int         checks = 0;
    int         errors = 0;
    int         seq_cnt[3] = '{0, 0, 0};
    int         exp_seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!rst_sys) begin
            for (int d = 0; d < 3; d++) begin
                if (o_seq[d]) seq_cnt[d]++;
                if (o_vld[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected_result: actual dout=%h, expected no result", d, o_dout[d]);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        chk($sformatf("dut%0d_dout", d), o_dout[d], mon_e.dout);
                        chk($sformatf("dut%0d_ok", d), {31'h0, o_ok[d]}, {31'h0, mon_e.ok});
                        chk($sformatf("dut%0d_len", d), {16'h0, o_len[d]}, {16'h0, mon_e.len});
                        chk($sformatf("dut%0d_latency_cycle", d), cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    // Reference: bit-serial reflected LFSR, one wire bit at a time, LSB first.
    function automatic logic [31:0] ref_reg();
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (fbytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ fbytes[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB8_8320;
            end
        end
        return r;
    endfunction

    function automatic exp_t ref_result(input logic fmode);
        exp_t        e;
        logic [31:0] r;
        int          n;
        n      = fbytes.size();
        r      = ref_reg();
        e.dout = r ^ 32'hFFFF_FFFF;
        e.ok   = fmode && (r == 32'hDEBB_20E3) && (n >= 4);
        e.len  = (n > 65535) ? 16'hFFFF : 16'(n);
        e.cyc  = 0;
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        vld  = 1'b0; sop  = 1'($urandom); eop  = 1'($urandom); mode  = 1'($urandom);
        din  = $urandom; keep = 4'($urandom);
        vld1 = 1'b0; sop1 = 1'($urandom); eop1 = 1'($urandom); mode1 = 1'($urandom);
        din1 = 8'($urandom); keep1 = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic load_vec(input logic [127:0] d, input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(d[8*i +: 8]);
    endtask

    task automatic gen_rand(input logic fmode, input int max_n);
        logic [31:0] fcs;
        int          n;
        fbytes.delete();
        n = $urandom_range(0, max_n);
        for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom));
        if (fmode && ($urandom_range(0, 1) == 1)) begin
            fcs = ref_reg() ^ 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) fbytes.push_back(fcs[8*i +: 8]);
        end
    endtask

    // 4-byte instances; dk/okk select table constants instead of model values.
    task automatic send4(input logic fmode, input int max_gap, input bit etail,
                         input bit dk, input logic [31:0] cd, input bit okk, input logic cok);
        exp_t e;
        int   n, total, idx;
        n      = fbytes.size();
        e      = ref_result(fmode);
        if (dk)  e.dout = cd;
        if (okk) e.ok   = cok;
        total  = (n + 3) / 4 + (((n == 0) || (etail && (n % 4 == 0))) ? 1 : 0);
        for (int j = 0; j < total; j++) begin
            vld  = 1'b1;
            sop  = (j == 0);
            eop  = (j == total - 1);
            mode = (j == 0) ? fmode : 1'($urandom);
            din  = $urandom;
            keep = eop ? 4'h0 : 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                idx = 4 * j + k;
                if (idx < n) begin
                    din[8*k +: 8] = fbytes[idx];
                    if (eop) keep[k] = 1'b1;
                end
            end
            if (eop) begin
                e.cyc = cyc + 1;
                exp_q[0].push_back(e);
                e.cyc = cyc + 2;
                exp_q[2].push_back(e);
            end
            tick();
            idle_inputs();
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic send1(input logic fmode, input int max_gap, input bit etail,
                         input bit dk, input logic [31:0] cd);
        exp_t e;
        int   n, total;
        n     = fbytes.size();
        e     = ref_result(fmode);
        if (dk) e.dout = cd;
        total = n + (((n == 0) || etail) ? 1 : 0);
        for (int j = 0; j < total; j++) begin
            vld1  = 1'b1;
            sop1  = (j == 0);
            eop1  = (j == total - 1);
            mode1 = (j == 0) ? fmode : 1'($urandom);
            din1  = (j < n) ? fbytes[j] : 8'($urandom);
            keep1 = eop1 ? ((j < n) ? 1'b1 : 1'b0) : 1'($urandom);
            if (eop1) begin
                e.cyc = cyc + 1;
                exp_q[1].push_back(e);
            end
            tick();
            idle_inputs();
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_dut%0d_dout", tag, d), o_dout[d], 32'h0);
            chk($sformatf("%s_dut%0d_vld", tag, d), {31'h0, o_vld[d]}, 32'h0);
            chk($sformatf("%s_dut%0d_ok", tag, d), {31'h0, o_ok[d]}, 32'h0);
            chk($sformatf("%s_dut%0d_len", tag, d), {16'h0, o_len[d]}, 32'h0);
            chk($sformatf("%s_dut%0d_seq_err", tag, d), {31'h0, o_seq[d]}, 32'h0);
        end
    endtask

    // ---------------- known vectors ----------------
    typedef struct {
        logic         mode;
        int           n;
        logic [127:0] data;
        bit           dk;
        logic [31:0]  dout;
        logic         ok;
    } vec_t;

    localparam logic [71:0] S9 = 72'h39_38_37_36_35_34_33_32_31;
    vec_t tbl[8];

    initial begin
        logic [71:0] s9_flip;
        logic [63:0] s8;
        s9_flip    = S9;
        s9_flip[32] = ~s9_flip[32];
        s8         = S9[63:0];

        tbl[0] = '{1'b0, 9,  {56'h0, S9},                1'b1, 32'hCBF4_3926, 1'b0};
        tbl[1] = '{1'b1, 13, {24'h0, 32'hCBF4_3926, S9}, 1'b1, 32'h2144_DF1C, 1'b1};
        tbl[2] = '{1'b1, 13, {24'h0, 32'hCBF4_3926, s9_flip}, 1'b0, 32'h0, 1'b0};
        tbl[3] = '{1'b0, 1,  128'h61,                    1'b1, 32'hE8B7_BE43, 1'b0};
        tbl[4] = '{1'b1, 3,  128'h33_32_31,              1'b0, 32'h0, 1'b0};
        tbl[5] = '{1'b0, 0,  128'h0,                     1'b1, 32'h0000_0000, 1'b0};
        tbl[6] = '{1'b1, 4,  128'h0,                     1'b1, 32'h2144_DF1C, 1'b1};
        tbl[7] = '{1'b0, 8,  {64'h0, s8},                1'b0, 32'h0, 1'b0};

        rst_sys = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk_sys);
        #1;
        chk_zero("reset_state");
        @(negedge clk_sys);
        rst_sys = 1'b0;
        tick();

        // table: back-to-back without gaps, then with gaps and empty eop tails
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 0; t < 8; t++) begin
                load_vec(tbl[t].data, tbl[t].n);
                send4(tbl[t].mode, (pass == 0) ? 0 : 3, pass == 1, tbl[t].dk, tbl[t].dout, 1'b1, tbl[t].ok);
            end
        end

        // single-byte instance
        load_vec({56'h0, S9}, 9);
        send1(1'b0, 0, 1'b0, 1'b1, 32'hCBF4_3926);
        load_vec({56'h0, S9}, 9);
        send1(1'b0, 2, 1'b1, 1'b1, 32'hCBF4_3926);
        for (int i = 0; i < 8; i++) begin
            mode1 = 1'($urandom);
            gen_rand(mode1, 12);
            send1(mode1, 1, 1'($urandom), 1'b0, 32'h0);
        end

        // beat without sop while idle: discarded with a seq_err pulse
        vld = 1'b1; sop = 1'b0; eop = 1'($urandom); keep = 4'hF; din = $urandom;
        exp_seq++;
        tick();
        idle_inputs();
        chk("seq_err_idle_pulse_dut0", {31'h0, o_seq[0]}, 32'h1);
        chk("seq_err_idle_pulse_dut2", {31'h0, o_seq[2]}, 32'h1);
        tick();
        chk("seq_err_idle_pulse_end", {31'h0, o_seq[0]}, 32'h0);

        // sop mid-frame: first frame dropped, restarted frame correct
        vld = 1'b1; sop = 1'b1; eop = 1'b0; mode = 1'b1; din = $urandom;
        tick();
        vld = 1'b1; sop = 1'b0; eop = 1'b0; din = $urandom;
        tick();
        exp_seq++;
        load_vec({56'h0, S9}, 9);
        send4(1'b0, 0, 1'b0, 1'b1, 32'hCBF4_3926, 1'b0, 1'b0);
        vld = 1'b1; sop = 1'b1; eop = 1'b0; mode = 1'b0; din = $urandom;
        tick();
        exp_seq++;
        load_vec(128'h61, 1);
        send4(1'b0, 0, 1'b0, 1'b1, 32'hE8B7_BE43, 1'b0, 1'b0);

        // reset in the middle of a frame
        vld = 1'b1; sop = 1'b1; eop = 1'b0; mode = 1'b1; din = $urandom;
        tick();
        vld = 1'b1; sop = 1'b0; eop = 1'b0; din = $urandom;
        tick();
        idle_inputs();
        #2 rst_sys = 1'b1;
        #1 chk_zero("reset_mid_frame");
        @(negedge clk_sys);
        rst_sys = 1'b0;
        tick();

        // reset right after an eop: pending results (incl. the extra stage) dropped
        load_vec({64'h0, s8}, 8);
        send4(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst_sys = 1'b1;
        exp_q[0].delete();
        exp_q[2].delete();
        #1 chk_zero("reset_after_eop");
        @(negedge clk_sys);
        rst_sys = 1'b0;
        tick();

        load_vec({56'h0, S9}, 9);
        send4(1'b0, 1, 1'b0, 1'b1, 32'hCBF4_3926, 1'b1, 1'b0);
        load_vec(128'h33_32_31, 3);
        send4(1'b1, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // random frames against the model
        for (int i = 0; i < 40; i++) begin
            mode = 1'($urandom);
            gen_rand(mode, 24);
            send4(mode, $urandom_range(0, 2), 1'($urandom), 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // length saturation: CRC keeps running past 16'hFFFF bytes
        fbytes.delete();
        for (int i = 0; i < 65540; i++) fbytes.push_back(8'($urandom));
        send4(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        repeat (10) tick();
        for (int d = 0; d < 3; d++)
            chk($sformatf("dut%0d_results_outstanding", d), exp_q[d].size(), 32'h0);
        chk("dut0_seq_err_count", seq_cnt[0], exp_seq);
        chk("dut2_seq_err_count", seq_cnt[2], exp_seq);
        chk("dut1_seq_err_count", seq_cnt[1], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
